rv32i_test_monitor: RTL and testbench
=====================================

// Module: rv32i_test_monitor
// PURPOSE
// - Synthesizable end-of-test monitor that sits directly downstream of rv32i_core.
// - Consumes the core's ecall strobe and the x3 (gp) value, and produces a sticky verdict:
//   pass, fail or timeout.
// - Replaces bench-side polling, so sim and FPGA builds report riscv-tests results identically.
// - Extracts the failing test number from the riscv-tests gp encoding (gp = testnum<<1 | 1).
// PARAMETERS
// - TIMEOUT_CYCLES  5000  RUN cycles allowed before a timeout verdict; must be >= 1.
// - CNT_W           32    width of cycle/retire counters; must satisfy 2**CNT_W > TIMEOUT_CYCLES.
// PORTS
// - clk           in   1       core clock, rising edge
// - rst_n         in   1       asynchronous, active-low reset
// - start         in   1       pulse: arm monitor / clear counters; honoured in any state
// - is_ecall      in   1       core decodes an ECALL this cycle
// - gp_value      in   32      current regfile x3 contents
// - busy          out  1       state == RUN
// - done          out  1       state in {PASS, FAIL, TIMEOUT}
// - pass          out  1       verdict: ecall with gp == 32'h1
// - fail          out  1       verdict: ecall with gp != 32'h1
// - timeout       out  1       verdict: no ecall within TIMEOUT_CYCLES
// - fail_testnum  out  31      gp_value[31:1] latched on fail; 0 otherwise
// - cycle_cnt     out  CNT_W   RUN cycles elapsed; frozen on verdict
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
// - Reset: state=IDLE; all outputs and counters = 0.
// - FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered, decoded from
//   state plus latched registers.
// - Transitions from any state:
//   - start sampled high -> RUN next cycle; cycle_cnt=0; fail_testnum=0; verdict bits clear.
//   - start outranks every other event in the same cycle.
// - Transitions in RUN (start low), priority order:
//   - is_ecall & gp_value==1 -> PASS.
//   - is_ecall & gp_value!=1 -> FAIL; fail_testnum <= gp_value[31:1].
//   - cycle_cnt == TIMEOUT_CYCLES-1 -> TIMEOUT.
//   - otherwise cycle_cnt <= cycle_cnt+1.
// - Ecall vs timeout: an ecall on the same cycle as the timeout limit wins (PASS/FAIL).
// - Latency: verdict visible 1 cycle after the ecall cycle. cycle_cnt holds the value it had
//   on the ecall/limit cycle.
// - IDLE and terminal states ignore is_ecall; terminal states hold until start or reset.
// - Exactly one of pass/fail/timeout is high when done=1; all three are low otherwise.
// - gp_value is sampled only on an ecall cycle; X on gp outside ecall cycles must not
//   propagate.
// - Reset mid-RUN: immediate return to IDLE; nothing is retained.
// - cycle_cnt never wraps: the parameter constraint guarantees this. Elaboration $error if
//   the constraint is violated.
// CONFIGURATION
// - Macro RV32I_TEST_MON_RETIRE_CNT_EN.
// - Defined: adds ports retire (in, 1) and retire_cnt (out, CNT_W).
//   - retire_cnt clears on reset/start.
//   - Increments on each RUN cycle with retire=1, including the ecall cycle.
//   - Frozen in terminal states; saturates at all-ones.
// - Undefined: neither port exists; no retire logic is built.
// TESTING
// - Reset then start; is_ecall high 20 cycles later with gp=1 -> pass=1, done=1, busy=0,
//   cycle_cnt=20, fail_testnum=0.
// - start; ecall with gp=32'h0000_0007 -> fail=1, fail_testnum=3, pass=0, timeout=0.
// - TIMEOUT_CYCLES=16, no ecall -> timeout=1 exactly 16 cycles after RUN entry;
//   cycle_cnt=15. Ecall on that 16th cycle instead -> pass/fail, not timeout.
// - Ecall in IDLE and again after PASS -> ignored, verdict unchanged. start while in FAIL
//   -> RUN, all verdict bits 0, cycle_cnt=0.
// - rst_n asserted mid-RUN, asynchronously between edges -> outputs 0 immediately; IDLE
//   after release.
// - With RV32I_TEST_MON_RETIRE_CNT_EN: retire high on 12 of 20 RUN cycles before a pass
//   -> retire_cnt=12; retire_cnt frozen afterwards.

Source files
------------

// File: rtl/rv32i_test_monitor_if.sv
// Signal bundle between the rv32i_core side (master) and the end-of-test monitor (slave).
// The retire/retire_cnt pair exists only when RV32I_TEST_MON_RETIRE_CNT_EN is defined.
interface rv32i_test_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             is_ecall;
  logic [31:0]      gp_value;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [30:0]      fail_testnum;
  logic [CNT_W-1:0] cycle_cnt;
`ifdef RV32I_TEST_MON_RETIRE_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output start, is_ecall, gp_value, retire,
    input  busy, done, pass, fail, timeout, fail_testnum, cycle_cnt, retire_cnt
  );
  modport slave (
    input  start, is_ecall, gp_value, retire,
    output busy, done, pass, fail, timeout, fail_testnum, cycle_cnt, retire_cnt
  );
`else
  modport master (
    output start, is_ecall, gp_value,
    input  busy, done, pass, fail, timeout, fail_testnum, cycle_cnt
  );
  modport slave (
    input  start, is_ecall, gp_value,
    output busy, done, pass, fail, timeout, fail_testnum, cycle_cnt
  );
`endif
endinterface

// File: rtl/rv32i_test_monitor.sv
// End-of-test monitor for riscv-tests: turns ecall + gp into a sticky pass/fail/timeout verdict.
// Optional retire counter built when RV32I_TEST_MON_RETIRE_CNT_EN is defined.
module rv32i_test_monitor #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  rv32i_test_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rv32i_test_monitor: TIMEOUT_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("rv32i_test_monitor: 2**CNT_W must exceed TIMEOUT_CYCLES");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [30:0]      fail_testnum_q, fail_testnum_d;
  logic             busy_q, done_q, pass_q, fail_q, timeout_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    cycle_cnt_d    = cycle_cnt_q;
    fail_testnum_d = fail_testnum_q;
    if (mon.start) begin
      state_d        = ST_RUN;
      cycle_cnt_d    = '0;
      fail_testnum_d = '0;
    end else if (state_q == ST_RUN) begin
      // gp_value is only looked at under is_ecall, so X on it elsewhere never reaches state.
      if (mon.is_ecall) begin
        if (mon.gp_value == 32'h1) begin
          state_d = ST_PASS;
        end else begin
          state_d        = ST_FAIL;
          fail_testnum_d = mon.gp_value[31:1];
        end
      end else if (cycle_cnt_q == LIMIT) begin
        state_d = ST_TIMEOUT;
      end else begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef RV32I_TEST_MON_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (mon.start) begin
      retire_cnt_d = '0;
    end else if (state_q == ST_RUN && mon.retire && retire_cnt_q != '1) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign mon.retire_cnt = retire_cnt_q;
`endif

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  // Verdict flags are decoded from the next state, so they are registered yet track state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cycle_cnt_q    <= '0;
      fail_testnum_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycle_cnt_q    <= cycle_cnt_d;
      fail_testnum_q <= fail_testnum_d;
      busy_q         <= (state_d == ST_RUN);
      done_q         <= (state_d inside {ST_PASS, ST_FAIL, ST_TIMEOUT});
      pass_q         <= (state_d == ST_PASS);
      fail_q         <= (state_d == ST_FAIL);
      timeout_q      <= (state_d == ST_TIMEOUT);
    end
  end

  assign mon.busy         = busy_q;
  assign mon.done         = done_q;
  assign mon.pass         = pass_q;
  assign mon.fail         = fail_q;
  assign mon.timeout      = timeout_q;
  assign mon.fail_testnum = fail_testnum_q;
  assign mon.cycle_cnt    = cycle_cnt_q;

endmodule

// File: tb/tb_rv32i_test_monitor.sv
// Randomized self-checking bench for rv32i_test_monitor against a per-run verdict model.
// Builds with or without RV32I_TEST_MON_RETIRE_CNT_EN.
module tb_rv32i_test_monitor;

  localparam int T  = 16;
  localparam int CW = 32;

  localparam int V_RUN     = 0;
  localparam int V_PASS    = 1;
  localparam int V_FAIL    = 2;
  localparam int V_TIMEOUT = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rv32i_test_monitor_if #(.CNT_W(CW)) mon_if ();

  rv32i_test_monitor #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (mon_if)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_retire(input logic r);
`ifdef RV32I_TEST_MON_RETIRE_CNT_EN
    mon_if.retire = r;
`endif
  endtask

  task automatic check_retire(input string tag, input int exp);
`ifdef RV32I_TEST_MON_RETIRE_CNT_EN
    check({tag, "/retire_cnt"}, 64'(mon_if.retire_cnt), 64'(exp));
`endif
  endtask

  // Full output vector for a given verdict; V_RUN means still busy.
  task automatic check_verdict(input string tag, input int v, input logic [30:0] tn,
                               input int cnt);
    check({tag, "/busy"},         64'(mon_if.busy),         64'(v == V_RUN));
    check({tag, "/done"},         64'(mon_if.done),         64'(v != V_RUN));
    check({tag, "/pass"},         64'(mon_if.pass),         64'(v == V_PASS));
    check({tag, "/fail"},         64'(mon_if.fail),         64'(v == V_FAIL));
    check({tag, "/timeout"},      64'(mon_if.timeout),      64'(v == V_TIMEOUT));
    check({tag, "/fail_testnum"}, 64'(mon_if.fail_testnum), 64'(tn));
    check({tag, "/cycle_cnt"},    64'(mon_if.cycle_cnt),    64'(cnt));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "/busy"},      64'(mon_if.busy),      64'(0));
    check({tag, "/done"},      64'(mon_if.done),      64'(0));
    check({tag, "/pass"},      64'(mon_if.pass),      64'(0));
    check({tag, "/fail"},      64'(mon_if.fail),      64'(0));
    check({tag, "/timeout"},   64'(mon_if.timeout),   64'(0));
    check({tag, "/cycle_cnt"}, 64'(mon_if.cycle_cnt), 64'(0));
  endtask

  // One test run: start, ecall on RUN cycle ecall_at (negative = never), then hold.
  // Model: ecall inside the first T RUN cycles decides pass/fail with cycle_cnt = its index;
  // otherwise the run ends in timeout after T RUN cycles with cycle_cnt = T-1.
  task automatic run_case(input int ecall_at, input logic [31:0] gp, input string tag);
    int          last;
    int          v;
    int          cnt;
    int          exp_ret;
    logic [30:0] tn;
    exp_ret = 0;
    if (ecall_at >= 0 && ecall_at < T) begin
      last = ecall_at;
      cnt  = ecall_at;
      v    = (gp == 32'h1) ? V_PASS : V_FAIL;
      tn   = (gp == 32'h1) ? 31'd0 : gp[31:1];
    end else begin
      last = T - 1;
      cnt  = T - 1;
      v    = V_TIMEOUT;
      tn   = 31'd0;
    end

    @(negedge clk);
    mon_if.start    = 1'b1;
    mon_if.is_ecall = 1'($urandom_range(0, 1));
    mon_if.gp_value = 32'h1;
    set_retire(1'b1);
    @(negedge clk);
    mon_if.start = 1'b0;
    check_verdict({tag, "/start"}, V_RUN, 31'd0, 0);
    check_retire({tag, "/start"}, 0);

    for (int c = 0; c <= last; c++) begin
      mon_if.is_ecall = (c == ecall_at);
      mon_if.gp_value = (c == ecall_at) ? gp : 32'hx;
      set_retire(1'($urandom_range(0, 1)));
`ifdef RV32I_TEST_MON_RETIRE_CNT_EN
      if (mon_if.retire) exp_ret++;
`endif
      @(negedge clk);
      if (c < last && c == last / 2) begin
        check({tag, "/mid_busy"}, 64'(mon_if.busy),      64'(1));
        check({tag, "/mid_cnt"},  64'(mon_if.cycle_cnt), 64'(c + 1));
      end
    end
    mon_if.is_ecall = 1'b0;
    set_retire(1'b0);
    check_verdict(tag, v, tn, cnt);
    check_retire(tag, exp_ret);

    repeat (3) begin
      mon_if.is_ecall = 1'($urandom_range(0, 1));
      mon_if.gp_value = $urandom;
      set_retire(1'b1);
      @(negedge clk);
    end
    mon_if.is_ecall = 1'b0;
    set_retire(1'b0);
    check_verdict({tag, "/hold"}, v, tn, cnt);
    check_retire({tag, "/hold"}, exp_ret);
  endtask

  initial begin
    int          at;
    logic [31:0] gp;

    rst_n           = 1'b0;
    mon_if.start    = 1'b0;
    mon_if.is_ecall = 1'b0;
    mon_if.gp_value = 32'h0;
    set_retire(1'b0);
    #12;
    check_idle("reset");
    check({"reset", "/fail_testnum"}, 64'(mon_if.fail_testnum), 64'(0));
    check_retire("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    mon_if.is_ecall = 1'b1;
    mon_if.gp_value = 32'h1;
    repeat (3) @(negedge clk);
    mon_if.is_ecall = 1'b0;
    check_idle("idle_ecall");

    run_case(10,     32'h1,         "pass10");
    run_case(5,      32'h0000_0007, "fail7");
    run_case(-1,     32'h1,         "timeout");
    run_case(T - 1,  32'h1,         "limit_pass");
    run_case(T - 1,  32'h0000_0020, "limit_fail");
    run_case(T,      32'h1,         "late_ecall");
    run_case(0,      32'hffff_ffff, "fail_first");

    for (int i = 0; i < 20; i++) begin
      at = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T + 4));
      gp = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
      run_case(at, gp, $sformatf("rand%0d", i));
    end

    @(negedge clk);
    mon_if.start = 1'b1;
    @(negedge clk);
    mon_if.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check_retire("async_rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
